character_move_sequencer: RTL and testbench

- Upstream pixel sequencer for the player character. Sits between the keypad/game-logic pulses and the VGA adapter's plot interface.
- Tracks the character's lane (one of four) and accepts single-cycle move requests.
- For each accepted move, emits an erase pass of the 9x5 rectangle at the old lane, then a draw pass at the new lane, one pixel per clock.
- Also draws the character at lane 0 once after reset.

---
 rtl/character_move_sequencer_pkg.sv | 18 +
 rtl/character_move_sequencer_rect_scanner.sv | 29 ++
 rtl/character_move_sequencer.sv | 85 ++++++++
 tb/tb_character_move_sequencer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/character_move_sequencer_pkg.sv
// character_move_sequencer_pkg: geometry, colours and FSM states shared by the character plotting blocks
package character_move_sequencer_pkg;
    localparam int CHAR_W = 9;
    localparam int CHAR_H = 5;
    localparam logic [6:0] Y_BASE = 7'd102;
    localparam logic [2:0] BG_COLOR = 3'b111;
    localparam logic [2:0] CHAR_COLOR = 3'b100;
    localparam logic [7:0] LANE0_X = 8'd6;
    localparam logic [7:0] LANE1_X = 8'd24;
    localparam logic [7:0] LANE2_X = 8'd78;
    localparam logic [7:0] LANE3_X = 8'd132;

    typedef enum logic [1:0] {INIT, IDLE, ERASE, DRAW} state_t;

    function automatic logic [7:0] lane_x(input logic [1:0] lane);
        return lane == 2'd0 ? LANE0_X : lane == 2'd1 ? LANE1_X : lane == 2'd2 ? LANE2_X : LANE3_X;
    endfunction
endpackage

// File: rtl/character_move_sequencer_rect_scanner.sv
// rect_scanner: raster counters over a CHAR_W x CHAR_H rectangle, x inner and y outer
module rect_scanner
    import character_move_sequencer_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       start,
    input  logic       advance,
    output logic [3:0] xc,
    output logic [2:0] yc,
    output logic       last
);
    logic x_end;

    assign x_end = xc == 4'(CHAR_W - 1);
    assign last = x_end && yc == 3'(CHAR_H - 1);

    always_ff @(posedge Clock or negedge Reset)
        if (!Reset) begin
            xc <= '0;
            yc <= '0;
        end else if (start || (advance && last)) begin
            xc <= '0;
            yc <= '0;
        end else if (advance) begin
            xc <= x_end ? 4'd0 : xc + 4'd1;
            yc <= x_end ? yc + 3'd1 : yc;
        end
endmodule

// File: rtl/character_move_sequencer.sv
// character_move_sequencer: turns lane-move pulses into erase/draw pixel streams for the VGA plotter
module character_move_sequencer
    import character_move_sequencer_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       MoveLeft,
    input  logic       MoveRight,
    output logic [7:0] XOut,
    output logic [6:0] YOut,
    output logic [2:0] Color,
    output logic       Plot,
    output logic       Busy,
    output logic [1:0] CurPos
);
    state_t state, next_state;
    logic [1:0] tgt, next_tgt;
    logic req_l, req_r, go, scanning, last;
    logic [3:0] xc;
    logic [2:0] yc;

    assign scanning = state == ERASE || state == DRAW;
    assign Busy = state != IDLE || Plot;
    assign go = (req_l ^ req_r) && (req_l ? CurPos != 2'd0 : CurPos != 2'd3);

    rect_scanner u_scan (
        .Clock  (Clock),
        .Reset  (Reset),
        .start  (!scanning),
        .advance(scanning),
        .xc     (xc),
        .yc     (yc),
        .last   (last)
    );

    always_ff @(posedge Clock or negedge Reset)
        if (!Reset) begin
            state <= INIT;
            tgt <= '0;
        end else begin
            state <= next_state;
            tgt <= next_tgt;
        end

    always_comb begin
        next_state = state;
        next_tgt = tgt;
        case (state)
            INIT: begin
                next_state = DRAW;
                next_tgt = 2'd0;
            end
            IDLE: begin
                next_state = go ? ERASE : IDLE;
                next_tgt = go ? (req_l ? CurPos - 2'd1 : CurPos + 2'd1) : tgt;
            end
            ERASE: next_state = last ? DRAW : ERASE;
            DRAW: next_state = last ? IDLE : DRAW;
            default: next_state = INIT;
        endcase
    end

    // Requests seen while busy are masked here, so they are dropped rather than queued
    always_ff @(posedge Clock or negedge Reset)
        if (!Reset) begin
            req_l <= 1'b0;
            req_r <= 1'b0;
            CurPos <= '0;
            XOut <= '0;
            YOut <= '0;
            Color <= '0;
            Plot <= 1'b0;
        end else begin
            req_l <= MoveLeft && !Busy;
            req_r <= MoveRight && !Busy;
            if (state == ERASE && last)
                CurPos <= tgt;
            Plot <= scanning;
            if (scanning) begin
                XOut <= lane_x(CurPos) + 8'(xc);
                YOut <= Y_BASE + 7'(yc);
                Color <= state == ERASE ? BG_COLOR : CHAR_COLOR;
            end
        end
endmodule

// File: tb/tb_character_move_sequencer.sv
// tb_character_move_sequencer: random move pulses checked against a pass-level pixel schedule model
module tb_character_move_sequencer;
    logic Clock = 1'b0;
    logic Reset = 1'b0;
    logic MoveLeft = 1'b0;
    logic MoveRight = 1'b0;
    logic [7:0] XOut;
    logic [6:0] YOut;
    logic [2:0] Color;
    logic Plot, Busy;
    logic [1:0] CurPos;

    always #5 Clock = ~Clock;

    character_move_sequencer dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .MoveLeft (MoveLeft),
        .MoveRight(MoveRight),
        .XOut     (XOut),
        .YOut     (YOut),
        .Color    (Color),
        .Plot     (Plot),
        .Busy     (Busy),
        .CurPos   (CurPos)
    );

    typedef struct {int x; int y; int c;} pix_t;

    int n_checks = 0;
    int n_errors = 0;
    pix_t q[$];
    pix_t last_pix;
    int e, lane, new_lane, lane_edge, busy_start, plot_start, plot_end;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", tag, e, got, exp);
        end
    endtask

    function automatic int lane_x(input int l);
        return l == 0 ? 6 : l == 1 ? 24 : l == 2 ? 78 : 132;
    endfunction

    task automatic push_pass(input int l, input int c);
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 9; x++)
                q.push_back('{lane_x(l) + x, 102 + y, c});
    endtask

    // Edge 1 is the first rising edge after reset release; the init draw fills edges 2..46
    task automatic model_reset();
        e = 0;
        q.delete();
        push_pass(0, 4);
        lane = 0;
        lane_edge = -1;
        busy_start = 0;
        plot_start = 2;
        plot_end = 46;
        last_pix = '{0, 0, 0};
    endtask

    task automatic check_reset_values();
        check("rst_x", XOut, 0);
        check("rst_y", YOut, 0);
        check("rst_color", Color, 0);
        check("rst_plot", Plot, 0);
        check("rst_busy", Busy, 1);
        check("rst_curpos", CurPos, 0);
    endtask

    // Request sampled at edge k: erase pixels at k+2..k+46, draw pixels at k+47..k+91
    task automatic drive(input logic l, input logic r);
        int k;
        MoveLeft = l;
        MoveRight = r;
        k = e + 1;
        if ((l ^ r) && e > plot_end && (l ? lane > 0 : lane < 3)) begin
            new_lane = l ? lane - 1 : lane + 1;
            lane_edge = k + 46;
            busy_start = k + 1;
            plot_start = k + 2;
            plot_end = k + 91;
            push_pass(lane, 7);
            push_pass(new_lane, 4);
        end
    endtask

    task automatic step();
        pix_t p;
        logic exp_plot;
        @(posedge Clock);
        e++;
        #1;
        if (lane_edge == e) lane = new_lane;
        exp_plot = e >= plot_start && e <= plot_end;
        check("plot", Plot, exp_plot);
        check("busy", Busy, e >= busy_start && e <= plot_end);
        check("curpos", CurPos, lane);
        if (exp_plot && q.size() > 0) begin
            p = q.pop_front();
            last_pix = p;
        end else begin
            p = last_pix;
        end
        check(exp_plot ? "pix_x" : "hold_x", XOut, p.x);
        check(exp_plot ? "pix_y" : "hold_y", YOut, p.y);
        check(exp_plot ? "pix_color" : "hold_color", Color, p.c);
    endtask

    initial begin
        int k;
        model_reset();
        repeat (3) @(posedge Clock);
        #1 check_reset_values();
        @(negedge Clock) Reset = 1'b1;
        repeat (60) begin
            step();
            drive(0, 0);
        end
        drive(1, 0);
        step();
        drive(0, 0);
        step();
        drive(1, 1);
        step();
        drive(0, 0);
        repeat (3000) begin
            step();
            if ($urandom_range(0, 7) == 0)
                drive(1'($urandom), 1'($urandom));
            else
                drive(0, 0);
        end
        for (int i = 0; i < 200 && e <= plot_end; i++) begin
            step();
            drive(0, 0);
        end
        check("idle_before_abort", 32'(e > plot_end), 1);
        if (lane < 3) drive(0, 1);
        else drive(1, 0);
        k = e + 1;
        step();
        drive(0, 0);
        for (int i = 0; i < 100 && e < k + 66; i++) step();
        #2 Reset = 1'b0;
        #1 check_reset_values();
        model_reset();
        @(negedge Clock) Reset = 1'b1;
        repeat (60) begin
            step();
            drive(0, 0);
        end
        check("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
